// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

   localparam int UartDataBits = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO. The head word sits in its own register, so
// rdata is a flop output and does not change while the FIFO stays non-empty
// without a pop. Full and empty are derived from the occupancy counter, which
// lets the pointers wrap naturally.
module sync_fifo #(
   parameter int Width = 8,
   parameter int Depth = 8,
   localparam int PtrW = $clog2(Depth),
   localparam int LvlW = $clog2(Depth + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push,
   input  logic [Width-1:0] wdata,
   input  logic             pop,
   output logic [Width-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [LvlW-1:0]  level
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PtrW-1:0]  rd_next;
   logic [LvlW-1:0]  level_q, level_d;
   logic [Width-1:0] head_q, head_d;
   logic             do_push;
   logic             do_pop;

   assign full  = (level_q == LvlW'(Depth));
   assign empty = (level_q == '0);
   assign level = level_q;
   assign rdata = head_q;

   // A pop needs data present; a push into a full FIFO only lands when the same
   // cycle frees a slot, otherwise the word is dropped.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rd_next = rd_ptr_q + PtrW'(1);

   // Next pointers, occupancy and head word. When popping, the new head is the
   // next stored word, or the incoming word if the FIFO would otherwise drain.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      head_d   = head_q;
      if (do_push) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_next;
      end
      if (do_push && !do_pop) begin
         level_d = level_q + LvlW'(1);
      end else if (!do_push && do_pop) begin
         level_d = level_q - LvlW'(1);
      end
      if (do_pop) begin
         if (level_q > LvlW'(1)) begin
            head_d = mem_q[rd_next];
         end else if (do_push) begin
            head_d = wdata;
         end
      end else if (do_push && empty) begin
         head_d = wdata;
      end
   end

   // Storage array; contents are only meaningful between the pointers, so it
   // carries no reset.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wdata;
      end
   end

   // Pointer, level and head registers with synchronous reset to empty.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         head_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         head_q   <= head_d;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM with
// stop-bit check and line-break handling, feeding a small FWFT byte FIFO.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int ClockFrequency = 125_000_000,
   parameter int BaudRate       = 15_625_000,
   parameter int ClksPerBit     = ClockFrequency / BaudRate,
   parameter int Depth          = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         rx_i,
   output logic [UartDataBits-1:0]      rx_data_o,
   output logic                         rx_valid_o,
   input  logic                         rx_ready_i,
   output logic                         frame_err_o,
   output logic                         overflow_o,
   output logic [$clog2(Depth+1)-1:0]   fifo_level_o
);

   localparam int CntW = $clog2(ClksPerBit);
   localparam int BitW = $clog2(UartDataBits);
   localparam logic [CntW-1:0] HalfBitLast = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullBitLast = CntW'(ClksPerBit - 1);
   localparam logic [BitW-1:0] LastBit     = BitW'(UartDataBits - 1);

   if (ClksPerBit < 4 || (ClksPerBit % 2) != 0) begin : g_bad_clks_per_bit
      $error("uart_rx_fifo: ClksPerBit must be even and at least 4");
   end
   if (Depth < 2 || (Depth & (Depth - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: Depth must be a power of two and at least 2");
   end

   logic                    sync1_q, sync2_q;
   logic                    rxs;
   uart_rx_state_e          state_q, state_d;
   logic [CntW-1:0]         clkcnt_q, clkcnt_d;
   logic [BitW-1:0]         bitcnt_q, bitcnt_d;
   logic [UartDataBits-1:0] data_q, data_d;
   logic                    push_q, push_d;
   logic                    frame_err_q, frame_err_d;
   logic                    overflow_q, overflow_d;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    fifo_pop;

   assign rxs = sync2_q;

   // Two-flop synchroniser on the asynchronous line; idles high out of reset
   // so a reset never looks like a start bit.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_i;
         sync2_q <= sync1_q;
      end
   end

   // Receive FSM next-state: the start bit is confirmed at its middle, so every
   // later full-bit wait lands mid-bit. A low stop bit means a break or framing
   // fault; the FSM then waits for the line to return high before re-arming.
   always_comb begin
      state_d     = state_q;
      clkcnt_d    = clkcnt_q + CntW'(1);
      bitcnt_d    = bitcnt_q;
      data_d      = data_q;
      push_d      = 1'b0;
      frame_err_d = 1'b0;
      unique case (state_q)
         IDLE: begin
            clkcnt_d = '0;
            if (!rxs) begin
               state_d = START;
            end
         end
         START: begin
            if (clkcnt_q == HalfBitLast) begin
               clkcnt_d = '0;
               bitcnt_d = '0;
               state_d  = rxs ? IDLE : DATA;
            end
         end
         DATA: begin
            if (clkcnt_q == FullBitLast) begin
               clkcnt_d         = '0;
               data_d[bitcnt_q] = rxs;
               if (bitcnt_q == LastBit) begin
                  state_d = STOP;
               end else begin
                  bitcnt_d = bitcnt_q + BitW'(1);
               end
            end
         end
         STOP: begin
            if (clkcnt_q == FullBitLast) begin
               clkcnt_d = '0;
               if (rxs) begin
                  push_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end
         end
         BREAK: begin
            clkcnt_d = '0;
            if (rxs) begin
               state_d = IDLE;
            end
         end
         default: begin
            clkcnt_d = '0;
            state_d  = IDLE;
         end
      endcase
   end

   // A byte is dropped only when a push meets a full FIFO that is not being
   // popped in the same cycle.
   always_comb begin
      overflow_d = push_q & fifo_full & ~fifo_pop;
   end

   // FSM state and registered pulse outputs; reset aborts any frame in flight
   // without producing a push or an error.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         clkcnt_q    <= '0;
         bitcnt_q    <= '0;
         data_q      <= '0;
         push_q      <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         clkcnt_q    <= clkcnt_d;
         bitcnt_q    <= bitcnt_d;
         data_q      <= data_d;
         push_q      <= push_d;
         frame_err_q <= frame_err_d;
         overflow_q  <= overflow_d;
      end
   end

   assign fifo_pop    = rx_ready_i & ~fifo_empty;
   assign rx_valid_o  = ~fifo_empty;
   assign frame_err_o = frame_err_q;
   assign overflow_o  = overflow_q;

   sync_fifo #(
      .Width(UartDataBits),
      .Depth(Depth)
   ) u_fifo (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .push  (push_q),
      .wdata (data_q),
      .pop   (fifo_pop),
      .rdata (rx_data_o),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level_o)
   );

endmodule
